// File: rtl/program_loader.sv
// program_loader: streams words into RAM, boots the computer and supervises the run; LOADER_CHECKSUM_EN enables the XOR checksum
module program_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_write,
  output logic              ram_en,
  output logic              cpu_reset,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int LIM   = TIMEOUT > 1 ? TIMEOUT - 2 : 0;
  typedef enum logic [2:0] {IDLE, LOAD, BOOT0, BOOT1, RUN, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [CW-1:0]     run_q, run_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              full, open_req, accept;
  assign full     = cnt_q == (ADDR_W+1)'(DEPTH);
  assign open_req = (state_q == IDLE || state_q == DONE) && load_req;
  assign accept   = state_q == LOAD && in_valid && !full;
  // next-state logic: session control, word capture and run supervision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    wr_d    = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE, DONE: if (load_req) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (in_valid) begin
        if (full) state_d = ERR;
        else begin
          wr_d    = 1'b1;
          adr_d   = in_addr;
          dat_d   = in_data;
          cnt_d   = cnt_q + 1'b1;
          state_d = in_last ? BOOT0 : LOAD;
        end
      end
      BOOT0: state_d = BOOT1;
      BOOT1: begin
        state_d = RUN;
        run_d   = '0;
      end
      RUN: begin
        run_d   = run_q + 1'b1;
        state_d = cpu_done ? DONE : (run_q >= CW'(LIM)) ? ERR : RUN;
      end
      default: ;
    endcase
  end
  // state and datapath registers; reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] ck_q, ck_d;
  // running XOR of counted words, cleared when a session opens
  always_comb ck_d = open_req ? '0 : accept ? ck_q ^ in_data : ck_q;
  // checksum register
  always_ff @(posedge clk) ck_q <= reset ? '0 : ck_d;
  assign checksum = ck_q;
`else
  logic unused_ck;
  assign unused_ck = open_req ^ accept;
  assign checksum  = '0;
`endif
  assign in_ready   = state_q == LOAD;
  assign ram_write  = wr_q & ~reset;
  assign ram_en     = ram_write;
  assign ram_in     = dat_q;
  assign ram_adr    = adr_q;
  assign cpu_reset  = state_q == BOOT0;
  assign cpu_start  = state_q == BOOT1;
  assign busy       = state_q == LOAD || state_q == BOOT0 || state_q == BOOT1 || state_q == RUN;
  assign done       = state_q == DONE;
  assign err        = state_q == ERR;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed stimulus with a behavioural reference model checked every cycle
module tb_program_loader;
  localparam int TO = 16;
  localparam int DEPTH = 8;
  localparam int P_IDLE = 0, P_LOAD = 1, P_BOOT0 = 2, P_BOOT1 = 3, P_RUN = 4, P_DONE = 5, P_ERR = 6;
  logic        clk = 1'b0, reset = 1'b1, load_req = 1'b0, in_valid = 1'b0, in_last = 1'b0, cpu_done = 1'b0;
  logic [2:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, ram_write, ram_en, cpu_reset, cpu_start, busy, done, err;
  logic [31:0] ram_in, checksum;
  logic [2:0]  ram_adr;
  logic [3:0]  word_count;
  int n_vec = 0, n_err = 0, cyc = 0;
  bit chk_on = 0;
  int m_ph = P_IDLE, m_cnt = 0, m_left = 0;
  bit m_wr = 0;
  logic [2:0]  m_adr = '0;
  logic [31:0] m_dat = '0, m_ck = '0;
  logic [2:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int rst_cyc = -1, start_cyc = -1, err_cyc = -1;
  bit err_seen = 0;

  program_loader #(.DATA_W(32), .ADDR_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last), .ram_in(ram_in), .ram_adr(ram_adr),
    .ram_write(ram_write), .ram_en(ram_en), .cpu_reset(cpu_reset), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .busy(busy), .done(done), .err(err), .word_count(word_count),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  // reference model: advances one session phase per clock from the rules
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ph = P_IDLE; m_cnt = 0; m_ck = '0; m_wr = 0; m_left = 0;
    end else begin
      m_wr = 0;
      if ((m_ph == P_IDLE || m_ph == P_DONE) && load_req) begin
        m_ph = P_LOAD; m_cnt = 0; m_ck = '0;
      end else if (m_ph == P_LOAD && in_valid) begin
        if (m_cnt == DEPTH) m_ph = P_ERR;
        else begin
          m_wr = 1; m_adr = in_addr; m_dat = in_data; m_cnt++; m_ck ^= in_data;
          if (in_last) m_ph = P_BOOT0;
        end
      end else if (m_ph == P_BOOT0) m_ph = P_BOOT1;
      else if (m_ph == P_BOOT1) begin
        m_ph = P_RUN; m_left = TO - 1;
      end else if (m_ph == P_RUN) begin
        if (cpu_done) m_ph = P_DONE;
        else begin
          m_left--;
          if (m_left <= 0) m_ph = P_ERR;
        end
      end
    end
  end

  // compare DUT outputs with the model and log observed events
  always @(negedge clk) begin
    if (chk_on) begin
      logic [31:0] exp_ck;
`ifdef LOADER_CHECKSUM_EN
      exp_ck = m_ck;
`else
      exp_ck = '0;
`endif
      chk("in_ready", in_ready, m_ph == P_LOAD);
      chk("busy", busy, m_ph == P_LOAD || m_ph == P_BOOT0 || m_ph == P_BOOT1 || m_ph == P_RUN);
      chk("done", done, m_ph == P_DONE);
      chk("err", err, m_ph == P_ERR);
      chk("cpu_reset", cpu_reset, m_ph == P_BOOT0);
      chk("cpu_start", cpu_start, m_ph == P_BOOT1);
      chk("ram_write", ram_write, m_wr && !reset);
      chk("ram_en", ram_en, m_wr && !reset);
      if (m_wr && !reset) begin
        chk("ram_adr", ram_adr, m_adr);
        chk("ram_in", ram_in, m_dat);
      end
      chk("word_count", word_count, m_cnt);
      chk("checksum", checksum, exp_ck);
    end
    if (ram_write) begin wa.push_back(ram_adr); wd.push_back(ram_in); wc.push_back(cyc); end
    if (cpu_reset) rst_cyc = cyc;
    if (cpu_start) start_cyc = cyc;
    if (err && !err_seen) begin err_seen = 1; err_cyc = cyc; end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [31:0] d, input logic l);
    in_valid = 1; in_addr = a; in_data = d; in_last = l;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic open_session();
    load_req = 1;
    tick();
    load_req = 0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 10 && !cpu_start; i++) tick();
    chk("start_seen", cpu_start, 1);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  initial begin
    tick();
    chk_on = 1;
    tick();
    reset = 0;
    tick(5);
    chk("t1_ready", in_ready, 0);
    chk("t1_wc", word_count, 0);
    chk("t1_busy", busy, 0);

    clear_log();
    open_session();
    send(3'd0, 32'h00003012, 0);
    send(3'd3, 32'd5, 0);
    send(3'd4, 32'd7, 1);
    chk("t2_wc", word_count, 3);
    wait_start();
    tick(3);
    cpu_done = 1;
    tick();
    cpu_done = 0;
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("t2_a0", wa[0], 0); chk("t2_a1", wa[1], 3); chk("t2_a2", wa[2], 4);
      chk("t2_d0", wd[0], 32'h00003012);
      chk("t2_b2b", wc[2] - wc[0], 2);
      chk("t2_lastwr_boot0", rst_cyc, wc[2]);
    end
    chk("t2_start_after_rst", start_cyc, rst_cyc + 1);
`ifdef LOADER_CHECKSUM_EN
    chk("t2_ck", checksum, 32'h00003010);
`else
    chk("t2_ck", checksum, 0);
`endif

    clear_log();
    open_session();
    for (int i = 0; i < 9; i++) send(3'(i % 8), 32'h100 + i, 0);
    chk("t3_err", err, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_wc", word_count, 8);
    @(negedge clk);
    #1;
    chk("t3_nwr", wa.size(), 8);
    if (wa.size() == 8) chk("t3_d7", wd[7], 32'h107);

    reset = 1;
    err_seen = 0;
    tick();
    reset = 0;
    open_session();
    send(3'd5, 32'hABCD, 1);
    wait_start();
    for (int i = 0; i < 40 && !err_seen; i++) tick();
    chk("t4_err_seen", err_seen, 1);
    chk("t4_err_cyc", err_cyc - start_cyc, 16);
    load_req = 1;
    tick(3);
    load_req = 0;
    chk("t4_sticky", err, 1);

    reset = 1;
    tick();
    reset = 0;
    open_session();
    send(3'd1, 32'd11, 0);
    send(3'd2, 32'd22, 0);
    reset = 1;
    clear_log();
    tick();
    reset = 0;
    tick(3);
    chk("t5_nwr", wa.size(), 0);
    chk("t5_wc", word_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 0);

    open_session();
    load_req = 1; cpu_done = 1;
    send(3'd1, 32'hFFFF0000, 0);
    load_req = 0; cpu_done = 0;
    send(3'd2, 32'h0000FFFF, 1);
    chk("t6_wc", word_count, 2);
`ifdef LOADER_CHECKSUM_EN
    chk("t6_ck", checksum, 32'hFFFFFFFF);
`else
    chk("t6_ck", checksum, 0);
`endif
    wait_start();
    tick(2);
    cpu_done = 1;
    tick();
    cpu_done = 0;
    chk("t6_done", done, 1);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
